data_mem_sized: RTL
===================

Name: data_mem_sized

Overview:
- Parametrised data memory for the MEM stage, replacing the fixed 2048×32 word RAM.
- Byte-addressed, little-endian, with byte/half/word loads and stores and sign or zero extension on loads.
- Registered one-cycle read with a valid strobe; misaligned, out-of-range and illegal accesses are flagged on an error strobe.
- Optional post-reset clear sequencer zeroes the array; a busy flag is high while it runs.

Parameters:
- DEPTH, 2048: number of 32-bit words; power of two, ≥ 2.
- ADDR_W, 32: byte address width.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset release; 0 = skip the sweep (contents undefined).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- addr  in  ADDR_W  byte address.
- data_in  in  32  store data; byte uses [7:0], half uses [15:0].
- memRead  in  1  load request.
- memWrite  in  1  store request.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- ld_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- data_out  out  32  registered load result.
- rd_valid  out  1  one-cycle pulse: data_out updated.
- err  out  1  one-cycle pulse: request rejected.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset: rst low asynchronously forces data_out=0, rd_valid=0, err=0 and clear pointer=0. State forced to CLEAR with busy=1 if CLEAR_ON_RESET=1, else IDLE with busy=0. Array contents are not reset asynchronously.
- States:
  - CLEAR: each cycle writes 0 to word[ptr], then ptr++. After the write of word DEPTH-1, go to IDLE with busy=0. Busy lasts exactly DEPTH cycles after the first clk edge with rst high.
  - In CLEAR, memRead and memWrite are ignored: no access, rd_valid=0, err=0.
  - IDLE: services requests.
  - rst low mid-sweep aborts the sweep; it restarts from word 0 on release.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
- A request is accepted only if all of the following hold:
  - exactly one of memRead/memWrite is high;
  - size != 11;
  - alignment is legal: half needs addr[0]=0, word needs addr[1:0]=0;
  - word index < DEPTH.
- Otherwise, when memRead or memWrite is high, err pulses on the next edge. The array is unchanged, data_out holds its value and rd_valid=0.
- memRead and memWrite both high is a rejected request (err=1); neither access is performed.
- Store: byte writes data_in[7:0] into lane addr[1:0]; half writes data_in[15:0] into lanes {addr[1],0} and {addr[1],1}; word writes all four lanes. Other lanes are preserved.
- Load: the word is read at the edge. The selected byte or half is right-justified into data_out and extended per ld_unsigned; a word is passed unmodified. Result and rd_valid=1 appear on the same edge, i.e. one cycle after the request.
- data_out holds its last value between loads.
- A store followed by a load of the same address on the next cycle returns the stored data; no forwarding is needed since the store is committed at its own edge.
- rd_valid and err are never high together.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: release rst → busy=1 for exactly 16 cycles, then 0. Word load of 0x3C → 0x00000000, rd_valid pulse.
- Word store 0xDEADBEEF @0x10, then loads:
  - byte @0x13 signed → 0xFFFFFFDE;
  - byte @0x13 unsigned → 0x000000DE;
  - half @0x12 signed → 0xFFFFDEAD;
  - byte @0x10 signed → 0xFFFFFFEF.
- Byte store 0x55 @0x11, then word load @0x10 → 0xDEAD55EF; half store 0x1234 @0x12, then word load → 0x123455EF.
- Rejected requests, each → err pulse, word @0x10 unchanged on re-read, rd_valid=0:
  - word store @0x12 (misaligned);
  - half load @0x11 (misaligned);
  - size=11;
  - store @0x40 with DEPTH=16 (out of range);
  - memRead=memWrite=1.
- Drop rst for 1 cycle at sweep cycle 5 after storing data → busy restarts a full 16 cycles; outputs are 0 during reset; previously stored word reads 0 after the sweep.
- CLEAR_ON_RESET=0: busy=0 immediately after reset. Word store, then word load on the next cycle → stored value, rd_valid exactly one cycle after the load request.

Source files
------------

// File: rtl/data_mem_sized_if.sv
// Request/response bundle for the MEM-stage data memory.
// The master drives requests; the memory drives load results and status strobes.
interface data_mem_sized_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic              memRead;
  logic              memWrite;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [31:0]       data_out;
  logic              rd_valid;
  logic              err;
  logic              busy;

  modport master (
    output addr, data_in, memRead, memWrite, size, ld_unsigned,
    input  data_out, rd_valid, err, busy
  );

  modport slave (
    input  addr, data_in, memRead, memWrite, size, ld_unsigned,
    output data_out, rd_valid, err, busy
  );
endinterface

// File: rtl/data_mem_sized.sv
// Byte-addressed little-endian data memory with sized loads/stores, registered reads,
// request checking and an optional post-reset zeroing sweep.
module data_mem_sized #(
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic              clk,
  input logic              rst,
  data_mem_sized_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [31:0]        mem [DEPTH];

  logic [1:0]         lane_c;
  logic [IDX_W-1:0]   idx_c;
  logic               any_req_c, align_ok_c, range_ok_c, req_ok_c;
  logic               accept_c, reject_c;
  logic [3:0]         wstrb_c;
  logic [31:0]        wdata_c;
  logic [IDX_W-1:0]   widx_c;
  logic [31:0]        rword_c, load_c;
  logic [7:0]         rbyte_c;
  logic [15:0]        rhalf_c;

  assign lane_c     = bus.addr[1:0];
  assign idx_c      = bus.addr[IDX_W+1:2];
  assign any_req_c  = bus.memRead | bus.memWrite;
  assign range_ok_c = 64'(bus.addr[ADDR_W-1:2]) < 64'(DEPTH);

  // Alignment rule depends on access size; size 11 never aligns.
  always_comb begin
    align_ok_c = 1'b0;
    case (bus.size)
      2'b00:   align_ok_c = 1'b1;
      2'b01:   align_ok_c = ~bus.addr[0];
      2'b10:   align_ok_c = (lane_c == 2'b00);
      default: align_ok_c = 1'b0;
    endcase
  end

  assign req_ok_c = (bus.memRead ^ bus.memWrite) & align_ok_c & range_ok_c;

  // Next-state: sweep pointer in CLEAR, request arbitration in IDLE.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    accept_c = 1'b0;
    reject_c = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        accept_c = req_ok_c;
        reject_c = any_req_c & ~req_ok_c;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Byte-lane write strobes; the sweep writes a full zero word. Nothing is written in reset.
  always_comb begin
    wstrb_c = 4'h0;
    wdata_c = 32'h0;
    widx_c  = ptr_q;
    if (state_q == S_CLEAR) begin
      wstrb_c = 4'hF;
    end else if (accept_c && bus.memWrite) begin
      widx_c = idx_c;
      case (bus.size)
        2'b00: begin
          wstrb_c = 4'b0001 << lane_c;
          wdata_c = {4{bus.data_in[7:0]}};
        end
        2'b01: begin
          wstrb_c = lane_c[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{bus.data_in[15:0]}};
        end
        2'b10: begin
          wstrb_c = 4'hF;
          wdata_c = bus.data_in;
        end
        default: wstrb_c = 4'h0;
      endcase
    end
    if (!rst) wstrb_c = 4'h0;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wstrb_c[b]) mem[widx_c][8*b +: 8] <= wdata_c[8*b +: 8];
    end
  end

  // Right-justify the addressed byte/half and extend it.
  always_comb begin
    rword_c = mem[idx_c];
    rbyte_c = rword_c[{lane_c, 3'b000} +: 8];
    rhalf_c = lane_c[1] ? rword_c[31:16] : rword_c[15:0];
    case (bus.size)
      2'b00:   load_c = bus.ld_unsigned ? {24'h0, rbyte_c} : {{24{rbyte_c[7]}}, rbyte_c};
      2'b01:   load_c = bus.ld_unsigned ? {16'h0, rhalf_c} : {{16{rhalf_c[15]}}, rhalf_c};
      default: load_c = rword_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out <= 32'h0;
      bus.rd_valid <= 1'b0;
      bus.err      <= 1'b0;
      bus.busy     <= (CLEAR_ON_RESET != 0);
    end else begin
      bus.rd_valid <= accept_c & bus.memRead;
      bus.err      <= reject_c;
      bus.busy     <= (state_d == S_CLEAR);
      if (accept_c && bus.memRead) bus.data_out <= load_c;
    end
  end

endmodule
